// File: rtl/ptr_list_collector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ptr_list_collector_pkg                                           |
// | Brief   : Shared types for the pointer-list collector and its record FIFO. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ptr_list_collector_pkg;

   localparam int N         = 256;
   localparam int W_PTR     = $clog2(N);
   localparam int W_LEN     = W_PTR;
   localparam int W_SUM     = 2 * W_PTR;
   localparam int REC_DEPTH = 4;

   typedef logic [W_PTR-1:0] ptr_t;
   typedef logic [W_LEN-1:0] len_t;
   typedef logic [W_SUM-1:0] sum_t;

   typedef struct packed {
      ptr_t head;
      ptr_t tail;
      len_t len;
      sum_t sum;
      logic loop;
   } rec_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } acc_state_t;

   // Longest list that is still counted; anything beyond is treated as a loop.
   localparam len_t LEN_MAX = len_t'(N - 1);

endpackage
`default_nettype wire

// File: rtl/ptr_list_collector_rec_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ptr_list_collector_rec_fifo                                      |
// | Brief   : Show-ahead FIFO of list summary records; reads 0 while empty.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ptr_list_collector_rec_fifo
   import ptr_list_collector_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  rec_t wr_data,
   input  logic pop,
   output rec_t rd_data,
   output logic empty,
   output logic full,
   output logic drop
);

   localparam int W_IDX = $clog2(DEPTH);
   localparam int W_CNT = W_IDX + 1;

   rec_t             r_mem [DEPTH];
   logic [W_IDX-1:0] r_wr_idx;
   logic [W_IDX-1:0] r_rd_idx;
   logic [W_CNT-1:0] r_cnt;
   logic             w_pop;
   logic             w_push;

   assign empty   = (r_cnt == '0);
   assign full    = (r_cnt == W_CNT'(DEPTH));
   assign w_pop   = pop & ~empty;
   // A pop in the same cycle frees the slot the push needs.
   assign w_push  = push & (~full | w_pop);
   assign drop    = push & full & ~w_pop;
   assign rd_data = empty ? '0 : r_mem[r_rd_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_idx <= r_wr_idx + 1'b1;
         if (w_pop)  r_rd_idx <= r_rd_idx + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_idx] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/ptr_list_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ptr_list_collector                                               |
// | Brief   : Segments a pointer stream into lists and queues one summary      |
// |           record per list behind a valid/ready handshake.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ptr_list_collector
   import ptr_list_collector_pkg::*;
#(
   parameter int DEPTH = REC_DEPTH
)
(
   input  logic clk,
   input  logic rst,
   input  ptr_t in_ptr,
   input  logic in_ptr_vld,
   output ptr_t rec_head,
   output ptr_t rec_tail,
   output len_t rec_len,
   output sum_t rec_sum,
   output logic rec_loop,
   output logic rec_vld,
   input  logic rec_rdy,
   output logic overflow,
   output logic null_err
);

   acc_state_t r_state;
   acc_state_t w_state_nxt;
   rec_t       r_acc;
   rec_t       w_acc_nxt;
   rec_t       w_rd_data;
   logic       w_push;
   logic       w_is_elem;
   logic       w_is_null;
   logic       w_empty;
   logic       w_full;
   logic       w_drop;
   logic       r_overflow;
   logic       r_null_err;

   // A null pointer is neither an element nor a gap.
   assign w_is_elem = in_ptr_vld & (in_ptr != '0);
   assign w_is_null = in_ptr_vld & (in_ptr == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_acc   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_push      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_is_elem) begin
               w_state_nxt    = ST_ACC;
               w_acc_nxt.head = in_ptr;
               w_acc_nxt.tail = in_ptr;
               w_acc_nxt.len  = len_t'(1);
               w_acc_nxt.sum  = sum_t'(in_ptr);
               w_acc_nxt.loop = 1'b0;
            end
         end
         ST_ACC: begin
            if (w_is_elem) begin
               if (r_acc.len < LEN_MAX) begin
                  w_acc_nxt.tail = in_ptr;
                  w_acc_nxt.len  = r_acc.len + len_t'(1);
                  w_acc_nxt.sum  = r_acc.sum + sum_t'(in_ptr);
               end else begin
                  w_acc_nxt.loop = 1'b1;
               end
            end else if (!in_ptr_vld) begin
               w_push      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
         r_null_err <= 1'b0;
      end else begin
         r_overflow <= r_overflow | w_drop;
         r_null_err <= r_null_err | w_is_null;
      end
   end

   ptr_list_collector_rec_fifo #(
      .DEPTH (DEPTH)
   ) u_rec_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (w_push),
      .wr_data (r_acc),
      .pop     (rec_rdy),
      .rd_data (w_rd_data),
      .empty   (w_empty),
      .full    (w_full),
      .drop    (w_drop)
   );

   assign rec_head = w_rd_data.head;
   assign rec_tail = w_rd_data.tail;
   assign rec_len  = w_rd_data.len;
   assign rec_sum  = w_rd_data.sum;
   assign rec_loop = w_rd_data.loop;
   assign rec_vld  = ~w_empty;
   assign overflow = r_overflow;
   assign null_err = r_null_err;

   // Full is only consumed inside the FIFO's drop decision.
   logic w_unused;
   assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_ptr_list_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ptr_list_collector                                            |
// | Brief   : Directed scoreboard bench for ptr_list_collector.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ptr_list_collector;
   import ptr_list_collector_pkg::*;

   localparam int TB_DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic in_ptr_vld;
   logic rec_rdy;
   ptr_t in_ptr;
   ptr_t rec_head;
   ptr_t rec_tail;
   len_t rec_len;
   sum_t rec_sum;
   logic rec_loop;
   logic rec_vld;
   logic overflow;
   logic null_err;

   ptr_list_collector #(.DEPTH(TB_DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_ptr     (in_ptr),
      .in_ptr_vld (in_ptr_vld),
      .rec_head   (rec_head),
      .rec_tail   (rec_tail),
      .rec_len    (rec_len),
      .rec_sum    (rec_sum),
      .rec_loop   (rec_loop),
      .rec_vld    (rec_vld),
      .rec_rdy    (rec_rdy),
      .overflow   (overflow),
      .null_err   (null_err)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   rec_t exp_q[$];
   rec_t m_acc;
   logic m_active;
   logic m_overflow;
   logic m_null;
   int   lst[$];

   function automatic rec_t mk(input int h, input int t, input int l, input int s, input bit lp);
      rec_t r;
      r.head = ptr_t'(h);
      r.tail = ptr_t'(t);
      r.len  = len_t'(l);
      r.sum  = sum_t'(s);
      r.loop = lp;
      return r;
   endfunction

   function automatic rec_t dut_rec();
      rec_t r;
      r = {rec_head, rec_tail, rec_len, rec_sum, rec_loop};
      return r;
   endfunction

   task automatic check_bit(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
      end
   endtask

   task automatic check_rec(input string tag, input rec_t got, input rec_t exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed h=%0d t=%0d l=%0d s=%0d lp=%0b expected h=%0d t=%0d l=%0d s=%0d lp=%0b",
                tag, got.head, got.tail, got.len, got.sum, got.loop,
                exp.head, exp.tail, exp.len, exp.sum, exp.loop);
      end
   endtask

   task automatic check_outputs();
      rec_t e;
      e = (exp_q.size() != 0) ? exp_q[0] : '0;
      check_bit("rec_vld", rec_vld, exp_q.size() != 0);
      check_rec("rec_data", dut_rec(), e);
      check_bit("overflow", overflow, m_overflow);
      check_bit("null_err", null_err, m_null);
   endtask

   // Drive one cycle, predict the clock edge, then compare at the next falling edge.
   task automatic cyc(input logic v, input int p, input logic r);
      in_ptr_vld = v;
      in_ptr     = ptr_t'(p);
      rec_rdy    = r;
      if (r && exp_q.size() != 0) void'(exp_q.pop_front());
      if (v && p == 0) begin
         m_null = 1'b1;
      end else if (v) begin
         if (!m_active) begin
            m_active = 1'b1;
            m_acc    = mk(p, p, 1, p, 1'b0);
         end else if (m_acc.len < len_t'(255)) begin
            m_acc.tail = ptr_t'(p);
            m_acc.len  = m_acc.len + 1'b1;
            m_acc.sum  = m_acc.sum + sum_t'(p);
         end else begin
            m_acc.loop = 1'b1;
         end
      end else if (m_active) begin
         m_active = 1'b0;
         if (exp_q.size() < TB_DEPTH) exp_q.push_back(m_acc);
         else m_overflow = 1'b1;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic send_list(input logic r);
      foreach (lst[i]) cyc(1'b1, lst[i], r);
      cyc(1'b0, 0, r);
   endtask

   task automatic send_first4(input logic r);
      lst = '{7, 15, 8};    send_list(r);
      lst = '{6};           send_list(r);
      lst = '{2, 4};        send_list(r);
      lst = '{1, 5, 3, 10}; send_list(r);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      in_ptr_vld = 1'b0;
      in_ptr     = '0;
      rec_rdy    = 1'b0;
      exp_q.delete();
      m_active   = 1'b0;
      m_overflow = 1'b0;
      m_null     = 1'b0;
      m_acc      = '0;
      @(negedge clk);
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   int seq4[4] = '{1, 5, 3, 10};

   initial begin
      do_reset();

      // Single list and its latency
      cyc(1'b1, 7, 1'b1);
      cyc(1'b1, 15, 1'b1);
      cyc(1'b1, 8, 1'b1);
      check_bit("t1_vld_before_gap", rec_vld, 1'b0);
      cyc(1'b0, 0, 1'b1);
      check_bit("t1_vld_two_after", rec_vld, 1'b1);
      check_rec("t1_rec", dut_rec(), mk(7, 8, 3, 30, 1'b0));
      repeat (3) cyc(1'b0, 0, 1'b1);

      // Five lists drained as they arrive
      send_first4(1'b1);
      lst = '{9, 14, 11, 13, 12}; send_list(1'b1);
      repeat (4) cyc(1'b0, 0, 1'b1);
      check_bit("t2_drained", rec_vld, 1'b0);

      // Five lists with no consumer: fifth is dropped
      send_first4(1'b0);
      lst = '{9, 14, 11, 13, 12}; send_list(1'b0);
      check_bit("t3_overflow", overflow, 1'b1);
      check_rec("t3_oldest", dut_rec(), mk(7, 8, 3, 30, 1'b0));
      repeat (3) cyc(1'b0, 0, 1'b1);
      check_rec("t3_fourth", dut_rec(), mk(1, 10, 4, 19, 1'b0));
      cyc(1'b0, 0, 1'b1);
      check_bit("t3_fifth_absent", rec_vld, 1'b0);

      // Push and pop together while full
      do_reset();
      send_first4(1'b0);
      lst = '{9, 14, 11, 13, 12};
      foreach (lst[i]) cyc(1'b1, lst[i], 1'b0);
      cyc(1'b0, 0, 1'b1);
      check_bit("t4_no_overflow", overflow, 1'b0);
      check_rec("t4_new_oldest", dut_rec(), mk(6, 6, 1, 6, 1'b0));
      cyc(1'b0, 0, 1'b0);
      repeat (3) cyc(1'b0, 0, 1'b1);
      check_rec("t4_last_kept", dut_rec(), mk(9, 12, 5, 59, 1'b0));
      cyc(1'b0, 0, 1'b1);
      check_bit("t4_drained", rec_vld, 1'b0);

      // Runaway list saturates
      for (int i = 0; i < 300; i++) cyc(1'b1, seq4[i % 4], 1'b1);
      cyc(1'b0, 0, 1'b1);
      check_rec("t5_loop_rec", dut_rec(), mk(1, 3, 255, 1206, 1'b1));
      cyc(1'b0, 0, 1'b1);

      // Reset mid-list discards everything queued
      send_first4(1'b0);
      cyc(1'b1, 9, 1'b0);
      cyc(1'b1, 14, 1'b0);
      cyc(1'b1, 11, 1'b0);
      do_reset();
      cyc(1'b1, 6, 1'b0);
      cyc(1'b0, 0, 1'b0);
      check_rec("t6_after_rst", dut_rec(), mk(6, 6, 1, 6, 1'b0));
      cyc(1'b0, 0, 1'b1);
      cyc(1'b0, 0, 1'b0);
      check_bit("t6_single", rec_vld, 1'b0);

      // Null pointer inside a list is ignored but flagged
      cyc(1'b1, 5, 1'b0);
      cyc(1'b1, 0, 1'b0);
      check_bit("t6_null_err", null_err, 1'b1);
      cyc(1'b1, 4, 1'b0);
      cyc(1'b0, 0, 1'b0);
      check_rec("t6_null_rec", dut_rec(), mk(5, 4, 2, 9, 1'b0));
      cyc(1'b0, 0, 1'b1);
      cyc(1'b0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
